// File: rtl/cdb_arbiter_if.sv
// ============================================================
// Module  : cdb_arbiter_if
// Purpose : Result-offer and broadcast signals of the CDB arbiter.
// Rev     : 1.0
// ============================================================
`default_nettype none

interface cdb_arbiter_if #(
  parameter int ROB_SIZE_LOG = 4
);
  logic                    alu_valid;
  logic [31:0]             alu_value;
  logic [ROB_SIZE_LOG-1:0] alu_robid;
  logic                    alu_ready;

  logic                    slb_valid;
  logic [31:0]             slb_value;
  logic [ROB_SIZE_LOG-1:0] slb_robid;
  logic                    slb_ready;

  logic                    cdb_valid;
  logic [31:0]             cdb_value;
  logic [ROB_SIZE_LOG-1:0] cdb_robid;
  logic                    cdb_src;

  // Requester / consumer side.
  modport master (
    output alu_valid, alu_value, alu_robid,
    input  alu_ready,
    output slb_valid, slb_value, slb_robid,
    input  slb_ready,
    input  cdb_valid, cdb_value, cdb_robid, cdb_src
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_value, alu_robid,
    output alu_ready,
    input  slb_valid, slb_value, slb_robid,
    output slb_ready,
    output cdb_valid, cdb_value, cdb_robid, cdb_src
  );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================
// Module  : cdb_arbiter
// Purpose : Round-robin common data bus arbiter with one result
//           FIFO per source (ALU, load buffer).
// Rev     : 1.0
// ============================================================
`default_nettype none

module cdb_arbiter #(
  parameter int ROB_SIZE_LOG = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         pred_fail_flag,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 32 + ROB_SIZE_LOG;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ENTRY_W-1:0] alu_mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] alu_mem_d [FIFO_DEPTH];
  logic [ENTRY_W-1:0] slb_mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] slb_mem_d [FIFO_DEPTH];

  logic [PTR_W-1:0] alu_head_q, alu_head_d, alu_tail_q, alu_tail_d;
  logic [PTR_W-1:0] slb_head_q, slb_head_d, slb_tail_q, slb_tail_d;
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d, slb_cnt_q, slb_cnt_d;

  logic                    last_grant_q, last_grant_d;
  logic                    cdb_valid_q, cdb_valid_d;
  logic [31:0]             cdb_value_q, cdb_value_d;
  logic [ROB_SIZE_LOG-1:0] cdb_robid_q, cdb_robid_d;
  logic                    cdb_src_q, cdb_src_d;

  logic               alu_ready, slb_ready;
  logic               alu_push, slb_push, alu_pop, slb_pop, grant_slb;
  logic [ENTRY_W-1:0] head_entry;

  // Ready comes from occupancy only, so requesters never see a combinational loop.
  assign alu_ready     = (alu_cnt_q < FULL_CNT);
  assign slb_ready     = (slb_cnt_q < FULL_CNT);
  assign bus.alu_ready = alu_ready;
  assign bus.slb_ready = slb_ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_value = cdb_value_q;
  assign bus.cdb_robid = cdb_robid_q;
  assign bus.cdb_src   = cdb_src_q;

  always_comb begin
    alu_mem_d    = alu_mem_q;
    slb_mem_d    = slb_mem_q;
    alu_head_d   = alu_head_q;
    alu_tail_d   = alu_tail_q;
    slb_head_d   = slb_head_q;
    slb_tail_d   = slb_tail_q;
    alu_cnt_d    = alu_cnt_q;
    slb_cnt_d    = slb_cnt_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_value_d  = cdb_value_q;
    cdb_robid_d  = cdb_robid_q;
    cdb_src_d    = cdb_src_q;
    alu_push     = 1'b0;
    slb_push     = 1'b0;
    alu_pop      = 1'b0;
    slb_pop      = 1'b0;
    grant_slb    = 1'b0;
    head_entry   = '0;

    if (pred_fail_flag) begin
      alu_head_d   = '0;
      alu_tail_d   = '0;
      slb_head_d   = '0;
      slb_tail_d   = '0;
      alu_cnt_d    = '0;
      slb_cnt_d    = '0;
      cdb_valid_d  = 1'b0;
      last_grant_d = 1'b1;
    end else if (rdy) begin
      alu_push = bus.alu_valid && alu_ready;
      slb_push = bus.slb_valid && slb_ready;

      // With both heads present the source that did not win last time goes.
      if ((alu_cnt_q != '0) && (slb_cnt_q != '0)) begin
        grant_slb = ~last_grant_q;
      end else begin
        grant_slb = (slb_cnt_q != '0);
      end
      alu_pop    = (alu_cnt_q != '0) && !grant_slb;
      slb_pop    = grant_slb;
      head_entry = grant_slb ? slb_mem_q[slb_head_q] : alu_mem_q[alu_head_q];

      if (alu_pop || slb_pop) begin
        cdb_valid_d  = 1'b1;
        cdb_value_d  = head_entry[ENTRY_W-1:ROB_SIZE_LOG];
        cdb_robid_d  = head_entry[ROB_SIZE_LOG-1:0];
        cdb_src_d    = grant_slb;
        last_grant_d = grant_slb;
      end else begin
        cdb_valid_d  = 1'b0;
      end

      if (alu_push) begin
        alu_mem_d[alu_tail_q] = {bus.alu_value, bus.alu_robid};
        alu_tail_d            = alu_tail_q + 1'b1;
      end
      if (slb_push) begin
        slb_mem_d[slb_tail_q] = {bus.slb_value, bus.slb_robid};
        slb_tail_d            = slb_tail_q + 1'b1;
      end
      if (alu_pop) alu_head_d = alu_head_q + 1'b1;
      if (slb_pop) slb_head_d = slb_head_q + 1'b1;

      alu_cnt_d = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(alu_pop);
      slb_cnt_d = slb_cnt_q + CNT_W'(slb_push) - CNT_W'(slb_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        alu_mem_q[i] <= '0;
        slb_mem_q[i] <= '0;
      end
      alu_head_q   <= '0;
      alu_tail_q   <= '0;
      slb_head_q   <= '0;
      slb_tail_q   <= '0;
      alu_cnt_q    <= '0;
      slb_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      cdb_valid_q  <= 1'b0;
      cdb_value_q  <= '0;
      cdb_robid_q  <= '0;
      cdb_src_q    <= 1'b0;
    end else begin
      alu_mem_q    <= alu_mem_d;
      slb_mem_q    <= slb_mem_d;
      alu_head_q   <= alu_head_d;
      alu_tail_q   <= alu_tail_d;
      slb_head_q   <= slb_head_d;
      slb_tail_q   <= slb_tail_d;
      alu_cnt_q    <= alu_cnt_d;
      slb_cnt_q    <= slb_cnt_d;
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_value_q  <= cdb_value_d;
      cdb_robid_q  <= cdb_robid_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================
// Module  : tb_cdb_arbiter
// Purpose : Directed self-checking bench for cdb_arbiter.
// Rev     : 1.0
// ============================================================
`default_nettype none

module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  logic pred_fail_flag = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  cdb_arbiter_if #(.ROB_SIZE_LOG(4)) bus ();

  cdb_arbiter #(.ROB_SIZE_LOG(4), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .pred_fail_flag (pred_fail_flag),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cdb(input string tag, input logic [31:0] val, input logic [3:0] rid,
                           input logic src);
    check({tag, "_valid"}, 64'(bus.cdb_valid), 64'(1'b1));
    check({tag, "_value"}, 64'(bus.cdb_value), 64'(val));
    check({tag, "_robid"}, 64'(bus.cdb_robid), 64'(rid));
    check({tag, "_src"},   64'(bus.cdb_src),   64'(src));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(bus.cdb_valid), 64'(1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.slb_valid = 1'b0;
  endtask

  task automatic offer_alu(input logic [31:0] v, input logic [3:0] r);
    bus.alu_valid = 1'b1;
    bus.alu_value = v;
    bus.alu_robid = r;
  endtask

  task automatic offer_slb(input logic [31:0] v, input logic [3:0] r);
    bus.slb_valid = 1'b1;
    bus.slb_value = v;
    bus.slb_robid = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int  ai;
    int  si;
    int  k;
    logic acc_a;
    logic acc_s;

    bus.alu_valid = 1'b0;
    bus.alu_value = '0;
    bus.alu_robid = '0;
    bus.slb_valid = 1'b0;
    bus.slb_value = '0;
    bus.slb_robid = '0;

    // Reset state
    #2;
    check("rst_valid", 64'(bus.cdb_valid), 64'(1'b0));
    check("rst_value", 64'(bus.cdb_value), 64'(32'h0));
    check("rst_robid", 64'(bus.cdb_robid), 64'(4'h0));
    check("rst_src",   64'(bus.cdb_src),   64'(1'b0));
    check("rst_alu_ready", 64'(bus.alu_ready), 64'(1'b1));
    check("rst_slb_ready", 64'(bus.slb_ready), 64'(1'b1));
    tick();
    tick();
    rst = 1'b1;
    rdy = 1'b1;

    // Single ALU push: visible only after the second edge
    offer_alu(32'h12345678, 4'd3);
    tick();
    idle();
    check_idle("t1_e1");
    tick();
    check_cdb("t1_e2", 32'h12345678, 4'd3, 1'b0);
    tick();
    check_idle("t1_e3");

    // Fill ALU FIFO, then hold with rdy=0 (last_grant=0 here, so load wins first)
    offer_alu(32'hA0000010, 4'd10);
    offer_slb(32'h50000020, 4'd2);
    tick();
    check_idle("t3_e1");
    offer_alu(32'hA0000011, 4'd11);
    bus.slb_valid = 1'b0;
    tick();
    check_cdb("t3_s20", 32'h50000020, 4'd2, 1'b1);
    check("t3_alu_full", 64'(bus.alu_ready), 64'(1'b0));
    rdy = 1'b0;
    offer_alu(32'hA0000012, 4'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cdb("t3_hold", 32'h50000020, 4'd2, 1'b1);
      check("t3_hold_ready", 64'(bus.alu_ready), 64'(1'b0));
    end
    rdy = 1'b1;
    tick();
    check_cdb("t3_a10", 32'hA0000010, 4'd10, 1'b0);
    check("t3_ready_back", 64'(bus.alu_ready), 64'(1'b1));
    tick();
    idle();
    check_cdb("t3_a11", 32'hA0000011, 4'd11, 1'b0);
    tick();
    check_cdb("t3_a12", 32'hA0000012, 4'd12, 1'b0);
    tick();
    check_idle("t3_drain");

    // Flush with two queued entries plus a same-cycle push
    offer_alu(32'hA0000001, 4'd1);
    offer_slb(32'h50000001, 4'd9);
    tick();
    check_idle("fl_pre");
    offer_alu(32'hA0000002, 4'd2);
    bus.slb_valid = 1'b0;
    pred_fail_flag = 1'b1;
    tick();
    pred_fail_flag = 1'b0;
    idle();
    check_idle("fl_e0");
    check("fl_alu_ready", 64'(bus.alu_ready), 64'(1'b1));
    check("fl_slb_ready", 64'(bus.slb_ready), 64'(1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("fl_after");
    end

    // Both sources offering for 8 cycles; flush left last_grant=1 so ALU goes first
    ai = 0;
    si = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 8) begin
        offer_alu(32'hA1000000 + 32'(ai), 4'(ai));
        offer_slb(32'h51000000 + 32'(si), 4'(8 + si));
      end else begin
        idle();
      end
      acc_a = bus.alu_ready;
      acc_s = bus.slb_ready;
      tick();
      if (c <= 8 && acc_a) ai++;
      if (c <= 8 && acc_s) si++;
      if (c == 2) check("t2_slb_full", 64'(bus.slb_ready), 64'(1'b0));
      if (c == 3) check("t2_alu_full", 64'(bus.alu_ready), 64'(1'b0));
      if (c >= 2 && c <= 11) begin
        if (c % 2 == 1) begin
          k = (c - 3) / 2;
          check_cdb("t2_slb", 32'h51000000 + 32'(k), 4'(8 + k), 1'b1);
        end else begin
          k = (c - 2) / 2;
          check_cdb("t2_alu", 32'hA1000000 + 32'(k), 4'(k), 1'b0);
        end
      end else begin
        check_idle("t2_idle");
      end
    end
    check("t2_alu_accepted", 64'(ai), 64'(5));
    check("t2_slb_accepted", 64'(si), 64'(5));

    // Asynchronous reset between edges with entries queued
    offer_alu(32'hA2000001, 4'd5);
    offer_slb(32'h52000001, 4'd6);
    tick();
    offer_alu(32'hA2000002, 4'd7);
    offer_slb(32'h52000002, 4'd13);
    tick();
    idle();
    check_cdb("ar_pre", 32'hA2000001, 4'd5, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check("ar_valid", 64'(bus.cdb_valid), 64'(1'b0));
    check("ar_value", 64'(bus.cdb_value), 64'(32'h0));
    check("ar_robid", 64'(bus.cdb_robid), 64'(4'h0));
    check("ar_src",   64'(bus.cdb_src),   64'(1'b0));
    check("ar_alu_ready", 64'(bus.alu_ready), 64'(1'b1));
    check("ar_slb_ready", 64'(bus.slb_ready), 64'(1'b1));
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("ar_after");
    end

    // First contested grant after reset goes to the ALU
    offer_alu(32'hA3000001, 4'd4);
    offer_slb(32'h53000001, 4'd14);
    tick();
    idle();
    check_idle("fg_e1");
    tick();
    check_cdb("fg_alu", 32'hA3000001, 4'd4, 1'b0);
    tick();
    check_cdb("fg_slb", 32'h53000001, 4'd14, 1'b1);
    tick();
    check_idle("fg_drain");

    // Load-only stream of 5 entries wrapping the depth-2 FIFO
    for (int i = 0; i <= 6; i++) begin
      if (i < 5) offer_slb(32'h54000000 + 32'(i), 4'(i + 1));
      else idle();
      tick();
      if (i == 0) check_idle("ld_first");
      else if (i <= 5) check_cdb("ld", 32'h54000000 + 32'(i - 1), 4'(i), 1'b1);
      else check_idle("ld_drain");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
